// File: rtl/uart_rx_sniffer_if.sv
// Byte-stream port of the UART sniffer: FIFO head byte with valid/ready handshake.
// Latency: pure wiring; out_valid/out_data are registered-state driven inside the sniffer.
// Backpressure: the consumer holds out_ready low to keep the head byte in place.
// Ports: out_valid (producer -> consumer), out_data[7:0] (producer -> consumer),
//        out_ready (consumer -> producer).
interface uart_rx_sniffer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/uart_rx_sniffer.sv
// Oversampling UART receiver (8-N-1, or 8-E-1 when UART_RX_PARITY_EN is defined) feeding a FWFT byte FIFO.
// Latency: byte is written on the stop-bit sample edge; out_valid/out_data show it the next cycle.
// Backpressure: out_ready gates pops; a byte arriving with the FIFO full (and no pop) is dropped and flags overrun.
// Ports: clk, rst_n (async active-low), rx_i (serial line, idles high), out_if (valid/ready byte stream),
//        frame_err_o / parity_err_o / overrun_o (sticky until reset), byte_cnt_o (bytes accepted into FIFO).
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity bit and PARITY state).
module uart_rx_sniffer #(
  parameter int BAUD_DIV = 868,
  parameter int FIFO_AW  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_i,
  uart_rx_sniffer_if.master   out_if,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                overrun_o,
  output logic [31:0]         byte_cnt_o
);

  localparam int TW    = $clog2(BAUD_DIV + 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [TW-1:0] HALF_BIT = TW'(BAUD_DIV / 2);
  localparam logic [TW-1:0] FULL_BIT = TW'(BAUD_DIV);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } state_e;

  // ---------------------------------------------------------------- sync
  logic sync1_q, sync2_q;
  logic rxs;

  // Flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end
  assign rxs = sync2_q;

  // ---------------------------------------------------------------- FSM
  state_e          state_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            frame_err_q;
  logic            timer_hit;
  logic            par_ok;

  // The timer counts down to 1; the sample happens on the edge that sees 1,
  // so a load of N places the sample exactly N edges after the load edge.
  assign timer_hit = (timer_q == TW'(1));

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  logic parity_err_q;
  assign par_ok       = ~par_bad_q;
  assign parity_err_o = parity_err_q;
`else
  assign par_ok       = 1'b1;
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_q <= ST_START;
            timer_q <= HALF_BIT;
          end
        end
        ST_START: begin
          if (timer_hit) begin
            if (rxs) begin
              state_q <= ST_IDLE;          // glitch shorter than half a bit
            end else begin
              state_q   <= ST_DATA;
              timer_q   <= FULL_BIT;
              bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
              par_bad_q <= 1'b0;
`endif
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_DATA: begin
          if (timer_hit) begin
            shift_q <= {rxs, shift_q[7:1]};  // LSB arrives first
            timer_q <= FULL_BIT;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (timer_hit) begin
            // Even parity: the parity bit must equal the XOR of the data bits.
            par_bad_q <= (rxs != ^shift_q);
            timer_q   <= FULL_BIT;
            state_q   <= ST_STOP;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (timer_hit) begin
            if (rxs) begin
              state_q <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) parity_err_q <= 1'b1;
`endif
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_IDLE;   // swallow a held-low break line
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (rxs) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign frame_err_o = frame_err_q;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]      byte_cnt_q;
  logic             overrun_q;
  logic             push_vld, push_acc, pop, fifo_empty, fifo_full;

  // The push fires combinationally on the stop-sample edge itself.
  assign push_vld   = (state_q == ST_STOP) && timer_hit && rxs && par_ok;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop        = !fifo_empty && out_if.out_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push_acc   = push_vld && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        byte_cnt_q <= byte_cnt_q + 32'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_vld && fifo_full && !pop) overrun_q <= 1'b1;
    end
  end

  assign out_if.out_valid = !fifo_empty;
  // Gate to zero when empty so stale or uninitialised storage never appears.
  assign out_if.out_data  = fifo_empty ? 8'h00 : mem[rd_ptr_q[FIFO_AW-1:0]];
  assign overrun_o        = overrun_q;
  assign byte_cnt_o       = byte_cnt_q;

endmodule

// File: tb/tb_uart_rx_sniffer.sv
module tb_uart_rx_sniffer;
  localparam int BAUD = 8;
  localparam int AW   = 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_OFS = 10;
`else
  localparam int STOP_OFS = 9;
`endif
  // Cycles from the edge before the start bit is driven to the stop-sample edge:
  // 2 sync flops + 1 detect edge + half bit + STOP_OFS bits.
  localparam int LAT = 3 + BAUD / 2 + STOP_OFS * BAUD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        frame_err, parity_err, overrun;
  logic [31:0] byte_cnt;

  uart_rx_sniffer_if u_if ();

  uart_rx_sniffer #(.BAUD_DIV(BAUD), .FIFO_AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx),
    .out_if      (u_if),
    .frame_err_o (frame_err),
    .parity_err_o(parity_err),
    .overrun_o   (overrun),
    .byte_cnt_o  (byte_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] got_q[$];
  int         pop_cyc_q[$];
  logic [7:0] exp_q[$];
  bit         rand_rdy = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_cnt;
  bit         exp_ferr, exp_perr;
  int         t_start;

  // Record every byte the consumer accepts (sampled mid-cycle, before the accepting edge).
  always @(negedge clk) begin
    if (u_if.out_valid && u_if.out_ready) begin
      got_q.push_back(u_if.out_data);
      pop_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_rdy) u_if.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(BAUD);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    send_bit(stop_b);
    rx = 1'b1;
  endtask

  task automatic check_drain(input string tag);
    check({tag, "_n"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
    pop_cyc_q.delete();
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    got_q.delete();
    exp_q.delete();
    pop_cyc_q.delete();
  endtask

  initial begin
    u_if.out_ready = 1'b1;
    rst_n = 1'b0;
    tick(2);
    // Reset values
    check("rst_valid", u_if.out_valid, 0);
    check("rst_data", u_if.out_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_cnt", byte_cnt, 0);
    rst_n = 1'b1;
    tick(3);

    // Basic frame with exact output latency
    t_start = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(2 * BAUD);
    check("basic_pop_cyc", pop_cyc_q.size() > 0 ? pop_cyc_q[0] : -1, t_start + LAT);
    exp_q.push_back(8'hA5);
    check_drain("basic");
    check("basic_cnt", byte_cnt, 1);
    check("basic_ferr", frame_err, 0);
    check("basic_ovr", overrun, 0);

    // Start-bit glitch then a good frame
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * BAUD);
    check("glitch_nopop", got_q.size(), 0);
    check("glitch_ferr", frame_err, 0);
    check("glitch_perr", parity_err, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(2 * BAUD);
    exp_q.push_back(8'h3C);
    check_drain("after_glitch");
    check("glitch_cnt", byte_cnt, 2);

    // Bad stop bit followed by a held-low break
    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    tick(40);
    rx = 1'b1;
    tick(2 * BAUD);
    check("break_ferr", frame_err, 1);
    check("break_nopop", got_q.size(), 0);
    check("break_cnt", byte_cnt, 2);
    send_frame(8'h11, 1'b1, 1'b0);
    tick(2 * BAUD);
    exp_q.push_back(8'h11);
    check_drain("after_break");
    check("after_break_cnt", byte_cnt, 3);

    // Overrun with a 4-deep FIFO and no consumer
    do_reset();
    u_if.out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 1'b0);
    tick(2 * BAUD);
    check("ovr_flag", overrun, 1);
    check("ovr_cnt", byte_cnt, 4);
    check("ovr_valid", u_if.out_valid, 1);
    u_if.out_ready = 1'b1;
    tick(10);
    for (int v = 1; v <= 4; v++) exp_q.push_back(8'(v));
    check_drain("ovr_drain");

    // Full FIFO: pop on the 5th byte's stop-sample edge makes room
    do_reset();
    u_if.out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) send_frame(8'(v), 1'b1, 1'b0);
    fork
      send_frame(8'h05, 1'b1, 1'b0);
      begin
        tick(LAT - 1);
        u_if.out_ready = 1'b1;
        tick(1);
        u_if.out_ready = 1'b0;
      end
    join
    tick(2 * BAUD);
    check("simul_ovr", overrun, 0);
    check("simul_cnt", byte_cnt, 5);
    u_if.out_ready = 1'b1;
    tick(10);
    for (int v = 1; v <= 5; v++) exp_q.push_back(8'(v));
    check_drain("simul_drain");

`ifdef UART_RX_PARITY_EN
    // Parity good and bad
    do_reset();
    send_frame(8'h07, 1'b1, 1'b0);
    tick(2 * BAUD);
    exp_q.push_back(8'h07);
    check_drain("par_good");
    check("par_good_perr", parity_err, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(2 * BAUD);
    check("par_bad_nopop", got_q.size(), 0);
    check("par_bad_perr", parity_err, 1);
    check("par_bad_cnt", byte_cnt, 1);
`endif

    // Randomised frames against a frame-level model
    do_reset();
    exp_cnt = 0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    rand_rdy = 1'b1;
    for (int f = 0; f < 16; f++) begin
      logic [7:0] b;
      int kind;
      b = 8'($urandom);
      kind = $urandom_range(0, 7);
      if (kind == 0) begin
        rx = 1'b0;
        tick($urandom_range(1, BAUD / 2 - 1));
        rx = 1'b1;
        tick(BAUD);
      end
      if (kind == 1) begin
        send_frame(b, 1'b0, 1'b0);
        exp_ferr = 1'b1;
        tick(BAUD);
      end
`ifdef UART_RX_PARITY_EN
      else if (kind == 2) begin
        send_frame(b, 1'b1, 1'b1);
        exp_perr = 1'b1;
      end
`endif
      else begin
        send_frame(b, 1'b1, 1'b0);
        exp_q.push_back(b);
        exp_cnt++;
      end
      tick($urandom_range(0, BAUD));
    end
    tick(2 * BAUD);
    rand_rdy = 1'b0;
    u_if.out_ready = 1'b1;
    tick(20);
    check_drain("rand");
    check("rand_cnt", byte_cnt, exp_cnt);
    check("rand_ferr", frame_err, 32'(exp_ferr));
`ifdef UART_RX_PARITY_EN
    check("rand_perr", parity_err, 32'(exp_perr));
`else
    check("rand_perr", parity_err, 0);
`endif
    check("rand_ovr", overrun, 0);

    // Reset mid-frame with a byte held in the FIFO
    u_if.out_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0);   // sets frame_err so reset has something to clear
    tick(2 * BAUD);
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(BAUD);
    check("mid_pre_valid", u_if.out_valid, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_valid", u_if.out_valid, 0);
    check("mid_data", u_if.out_data, 0);
    check("mid_cnt", byte_cnt, 0);
    check("mid_ferr", frame_err, 0);
    check("mid_perr", parity_err, 0);
    check("mid_ovr", overrun, 0);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    u_if.out_ready = 1'b1;
    tick(12 * BAUD);
    check("mid_nopartial", got_q.size(), 0);
    check("mid_cnt_after", byte_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_sniffer.md
# uart_rx_sniffer

Simulation-side UART receiver that consumes the serial `Tx` line driven by `riscv_top` and turns it into a byte stream the testbench can check or print. It oversamples the line and decodes 8-N-1 frames, optionally with even parity. Decoded bytes go into a first-word-fall-through FIFO with a valid/ready output port. Sticky error flags and a byte counter are exposed for end-of-run checks.

## Interface
- `BAUD_DIV`, 868: clock cycles per UART bit; must be ≥ 4.
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line from `riscv_top.Tx`; idles high.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_data`  out  8  FIFO head byte.
- `frame_err`  out  1  sticky; a stop bit was sampled low.
- `parity_err`  out  1  sticky; parity mismatch. Constant 0 when `UART_RX_PARITY_EN` is undefined.
- `overrun`  out  1  sticky; a byte was dropped because the FIFO was full.
- `byte_cnt`  out  32  count of bytes written into the FIFO; wraps modulo 2^32.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `byte_cnt`=0, FSM=IDLE. Both synchronizer flops reset to 1.
- `rx` passes through a 2-flop synchronizer. `rxs` denotes the synchronized value.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP, WAIT_IDLE.
- IDLE: when `rxs`=0, go to START and load the bit timer with BAUD_DIV/2 (floor).
- START: on timer expiry, re-sample `rxs`.
  - `rxs`=1: glitch; return to IDLE with no flag set.
  - `rxs`=0: go to DATA with timer = BAUD_DIV and bit index = 0.
- DATA: on each expiry, shift in `rxs` LSB-first. After bit 7, go to PARITY (macro) or STOP.
- PARITY: sample one bit. A mismatch against even parity of the data is recorded for this frame.
- STOP: sample one bit.
  - `rxs`=1 with no parity mismatch: push the byte and return to IDLE.
  - `rxs`=1 with a parity mismatch: set `parity_err`, discard the byte, return to IDLE.
  - `rxs`=0: set `frame_err`, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rxs`=1, then go to IDLE. A held-low break line therefore yields exactly one `frame_err` and no bytes.
- FIFO push when not full: write the byte, increment `byte_cnt`.
- FIFO push when full and no pop in the same cycle: drop the byte, set `overrun`, leave `byte_cnt` unchanged.
- Pop occurs when `out_valid && out_ready`. `out_ready` while empty has no effect.
- Simultaneous push and pop: both take effect, occupancy is unchanged. This holds when full as well; the push is accepted with no overrun.
- Pointers wrap modulo depth. Full/empty are distinguished by an extra pointer bit.
- Sticky flags clear only on reset.
- Reset asserted mid-frame aborts the frame immediately and empties the FIFO. No partial byte is ever output.

## Timing
- `rxs` lags `rx` by 2 cycles.
- Let t0 be the first cycle IDLE sees `rxs`=0.
  - Start re-check: t0 + BAUD_DIV/2.
  - Data bit k: t0 + BAUD_DIV/2 + (k+1)·BAUD_DIV.
  - Parity bit: +9·BAUD_DIV.
  - Stop bit: +9·BAUD_DIV without parity, +10·BAUD_DIV with parity.
- FIFO write occurs on the stop-sample edge. `out_valid`/`out_data` update on the following cycle.
- The FSM re-enters IDLE the cycle after the stop sample, so a next start bit is detected even when frames are back-to-back with a single stop bit.
- Pop: `out_data` shows the next entry the cycle after the accepting edge. `out_valid` drops the same cycle if the FIFO becomes empty.
- Throughput: one pop per cycle.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined: frame is start, 8 data bits, even parity, stop. The PARITY state exists, and a mismatch sets `parity_err` and discards the byte.
- Undefined: frame is 8-N-1 with no PARITY state, and `parity_err` is tied to 0.

## Test plan
- Basic frame, `BAUD_DIV`=8, `out_ready`=1: send 0xA5 → `out_data`=0xA5 with `out_valid` high one cycle, `byte_cnt`=1, all flags 0.
- Start glitch: drive `rx` low for 3 cycles, then high → no byte, FSM back in IDLE, flags 0. A following 0x3C is received correctly.
- Bad stop bit: send 0x55 with stop bit = 0, then hold `rx` low 40 cycles → `frame_err`=1, no byte, exactly one error. A subsequent 0x11 is received correctly.
- Overrun, `FIFO_AW`=2, `out_ready`=0: send 0x01 through 0x05 back-to-back → `overrun`=1, `byte_cnt`=4. Draining yields 0x01, 0x02, 0x03, 0x04.
- Full FIFO with simultaneous push/pop: pulse `out_ready` on the cycle of the 5th byte's stop-sample edge → no overrun, `byte_cnt`=5, drain yields 0x02 through 0x05.
- Parity, macro defined: 0x07 with parity bit 1 → received. 0x07 with parity bit 0 → `parity_err`=1, no byte. Apply `rst_n` low mid-frame → all outputs return to reset values.
